llr_init_sequencer: RTL and testbench

// - Sequences the channel-LLR initialisation for the LDPC decoder. Reads N sifted key bits from
//   key RAM, drives xi and qber_sel into the L(Pi) lookup table and writes each Q5.10 LLR into LLR RAM.
// - Sits between the key buffer and the decoder's variable-node memory. One run per codeword, start/done handshake.

---
 rtl/llr_init_sequencer_pkg.sv | 22 ++
 rtl/llr_init_sequencer_if.sv | 37 +++
 rtl/llr_init_sequencer_out_stage.sv | 59 +++++
 rtl/llr_init_sequencer.sv | 101 ++++++++++
 tb/tb_llr_init_sequencer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/llr_init_sequencer_pkg.sv
// Shared constants and types for the channel-LLR initialisation sequencer.
package llr_init_sequencer_pkg;

    // LLR word format: Q5.10 two's complement, sign bit equals the hard decision.
    localparam int LLR_W       = 15;
    localparam int Q_INT_BITS  = 5;
    localparam int Q_FRAC_BITS = 10;

    // QBER selector: codes 0..10 map to QBER 0.01..0.11.
    localparam int              QBER_W       = 4;
    localparam logic [QBER_W-1:0] QBER_SEL_MAX = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

    function automatic logic qber_sel_valid(input logic [QBER_W-1:0] sel);
        return sel <= QBER_SEL_MAX;
    endfunction

endpackage

// File: rtl/llr_init_sequencer_if.sv
// Bus bundle between the sequencer and its surroundings: control handshake,
// key RAM read port, external L(Pi) LUT and LLR RAM write port.
interface llr_init_sequencer_if #(
    parameter int ADDR_W = 10,
    parameter int LLR_W  = 15
);
    logic              start;
    logic [3:0]        qber_sel_in;
    logic              busy;
    logic              done;
    logic              err_qber;
    logic              key_rd_en;
    logic [ADDR_W-1:0] key_rd_addr;
    logic              key_rd_data;
    logic              lut_xi;
    logic [3:0]        lut_qber_sel;
    logic [LLR_W-1:0]  lut_llr;
    logic              llr_wr_en;
    logic [ADDR_W-1:0] llr_wr_addr;
    logic [LLR_W-1:0]  llr_wr_data;
    logic              llr_wr_hard;
    logic              llr_wr_ready;

    // Sequencer side.
    modport slave (
        input  start, qber_sel_in, key_rd_data, lut_llr, llr_wr_ready,
        output busy, done, err_qber, key_rd_en, key_rd_addr, lut_xi, lut_qber_sel,
               llr_wr_en, llr_wr_addr, llr_wr_data, llr_wr_hard
    );

    // Environment side (controller, RAMs, LUT).
    modport master (
        output start, qber_sel_in, key_rd_data, lut_llr, llr_wr_ready,
        input  busy, done, err_qber, key_rd_en, key_rd_addr, lut_xi, lut_qber_sel,
               llr_wr_en, llr_wr_addr, llr_wr_data, llr_wr_hard
    );
endinterface

// File: rtl/llr_init_sequencer_out_stage.sv
// Return path: a 1-entry skid for raw key bits plus the LLR output register.
// The skid only ever holds a raw bit; it is translated through the shared LUT
// port when it drains, so the LUT always sees the oldest pending bit.
module llr_out_stage #(
    parameter int LLR_W = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_v_i,      // key_rd_data valid this cycle
    input  logic             in_xi_i,     // key_rd_data
    output logic             lut_xi_o,
    input  logic [LLR_W-1:0] lut_llr_i,
    output logic             out_v_o,
    output logic [LLR_W-1:0] out_data_o,
    output logic             out_hard_o,
    input  logic             ready_i,
    output logic             xfer_o,
    output logic [1:0]       occ_o        // entries held after this cycle's transfer
);
    logic             skid_v_q, skid_xi_q;
    logic             out_v_q, out_hard_q;
    logic [LLR_W-1:0] out_data_q;
    logic             out_free;

    assign xfer_o     = out_v_q & ready_i;
    assign out_free   = ~out_v_q | ready_i;
    // Gate the raw bit with its valid so lut_xi rests at 0 between returns.
    assign lut_xi_o   = skid_v_q ? skid_xi_q : (in_v_i & in_xi_i);
    assign occ_o      = {1'b0, skid_v_q} + {1'b0, out_v_q} - {1'b0, xfer_o};
    assign out_v_o    = out_v_q;
    assign out_data_o = out_data_q;
    assign out_hard_o = out_hard_q;

    // Skid drains first; a bit arriving into a blocked output register parks in the skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_v_q   <= 1'b0;
            skid_xi_q  <= 1'b0;
            out_v_q    <= 1'b0;
            out_hard_q <= 1'b0;
            out_data_q <= '0;
        end else if (out_free) begin
            if (skid_v_q | in_v_i) begin
                out_v_q    <= 1'b1;
                out_data_q <= lut_llr_i;
                out_hard_q <= lut_xi_o;
            end else begin
                out_v_q    <= 1'b0;
            end
            // The incoming bit lands in the skid only if the skid was the one draining.
            skid_v_q  <= skid_v_q & in_v_i;
            skid_xi_q <= in_xi_i;
        end else if (in_v_i) begin
            skid_v_q  <= 1'b1;
            skid_xi_q <= in_xi_i;
        end
    end

endmodule

// File: rtl/llr_init_sequencer.sv
// Channel-LLR initialisation sequencer: reads N key bits, looks each one up
// in the external L(Pi) LUT and writes the Q5.10 LLR plus hard decision.
module llr_init_sequencer #(
    parameter int N      = 1024,
    parameter int ADDR_W = $clog2(N),
    parameter int LLR_W  = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    llr_init_sequencer_if.slave   bus
);
    import llr_init_sequencer_pkg::*;

    localparam logic [ADDR_W:0]   N_CNT   = (ADDR_W+1)'(N);
    localparam logic [ADDR_W-1:0] LAST_WR = ADDR_W'(N-1);

    seq_state_e        state_q;
    logic [ADDR_W:0]   rd_cnt_q;
    logic [ADDR_W-1:0] wr_cnt_q;
    logic [3:0]        qber_q;
    logic              busy_q, done_q, err_q, inflight_q;

    logic              rd_issue, xfer;
    logic [1:0]        stage_occ;
    logic [2:0]        occ;

    // At most two bits committed (in flight, parked or presented) keeps the
    // skid from overflowing while still sustaining one LLR per cycle.
    assign occ      = {2'b0, inflight_q} + {1'b0, stage_occ};
    assign rd_issue = (state_q == ST_RUN) && (rd_cnt_q < N_CNT) && (occ < 3'd2);

    assign bus.key_rd_en    = rd_issue;
    assign bus.key_rd_addr  = rd_cnt_q[ADDR_W-1:0];
    assign bus.lut_qber_sel = qber_q;
    assign bus.llr_wr_addr  = wr_cnt_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err_qber     = err_q;

    llr_out_stage #(.LLR_W(LLR_W)) u_out (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_v_i     (inflight_q),
        .in_xi_i    (bus.key_rd_data),
        .lut_xi_o   (bus.lut_xi),
        .lut_llr_i  (bus.lut_llr),
        .out_v_o    (bus.llr_wr_en),
        .out_data_o (bus.llr_wr_data),
        .out_hard_o (bus.llr_wr_hard),
        .ready_i    (bus.llr_wr_ready),
        .xfer_o     (xfer),
        .occ_o      (stage_occ)
    );

    // Run control: start/error handling, read/write counters and completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            qber_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            inflight_q <= rd_issue;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (qber_sel_valid(bus.qber_sel_in)) begin
                            state_q  <= ST_RUN;
                            busy_q   <= 1'b1;
                            qber_q   <= bus.qber_sel_in;
                            rd_cnt_q <= '0;
                            wr_cnt_q <= '0;
                        end else begin
                            err_q    <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (rd_issue)
                        rd_cnt_q <= rd_cnt_q + (ADDR_W+1)'(1);
                    if (xfer) begin
                        wr_cnt_q <= wr_cnt_q + ADDR_W'(1);
                        if (wr_cnt_q == LAST_WR) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_llr_init_sequencer.sv
// Self-checking bench: behavioural model of a run (expected read/write
// streams, busy/done/err timing) compared against the DUT on every cycle.
module tb_llr_init_sequencer;
    localparam int N  = 8;
    localparam int AW = 3;
    localparam int LW = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    llr_init_sequencer_if #(.ADDR_W(AW), .LLR_W(LW)) bus();

    llr_init_sequencer #(.N(N), .ADDR_W(AW), .LLR_W(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int rdy_mode = 0;            // 0: ready high, 1: random, 2: ready low
    logic key_mem [N];
    logic [LW-1:0] got_data [N];

    // External L(Pi) LUT: L = round(ln((1-p)/p) * 2^10), negated when xi = 1.
    function automatic logic [LW-1:0] lut_f(input logic xi, input logic [3:0] q);
        real p, l;
        int  li;
        if (q > 4'd10) return '0;
        p  = (real'(q) + 1.0) / 100.0;
        l  = $ln((1.0 - p) / p) * 1024.0;
        li = int'(l);
        return xi ? LW'(-li) : LW'(li);
    endfunction

    assign bus.lut_llr = lut_f(bus.lut_xi, bus.lut_qber_sel);

    // Key RAM: one-cycle read latency.
    always @(posedge clk) bus.key_rd_data <= bus.key_rd_en ? key_mem[bus.key_rd_addr] : 1'b0;

    // LLR RAM acceptance, changed just after each rising edge.
    initial begin
        bus.llr_wr_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       bus.llr_wr_ready = 1'b1;
                1:       bus.llr_wr_ready = 1'($urandom_range(0, 1));
                default: bus.llr_wr_ready = 1'b0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    int   wr_idx = 0, rd_idx = 0;
    logic m_busy = 0, m_err = 0, m_done = 0, m_xfer, m_last;
    logic [3:0] m_q = 0;
    logic prev_hold = 0, prev_hard;
    logic [AW-1:0] prev_addr;
    logic [LW-1:0] prev_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            wr_idx = 0; rd_idx = 0;
            m_busy = 0; m_err = 0; m_done = 0; prev_hold = 0;
        end else begin
            m_xfer = bus.llr_wr_en & bus.llr_wr_ready;
            m_last = 1'b0;
            chk("busy", bus.busy, m_busy);
            chk("err_qber", bus.err_qber, m_err);
            chk("done", bus.done, m_done);
            if (m_done) begin wr_idx = 0; rd_idx = 0; end
            if (prev_hold) begin
                chk("hold_en", bus.llr_wr_en, 1);
                chk("hold_addr", bus.llr_wr_addr, prev_addr);
                chk("hold_data", bus.llr_wr_data, prev_data);
                chk("hold_hard", bus.llr_wr_hard, prev_hard);
            end
            if (bus.key_rd_en) begin
                chk("rd_in_run", m_busy && rd_idx < N, 1);
                chk("key_rd_addr", bus.key_rd_addr, rd_idx[AW-1:0]);
                rd_idx++;
                chk("outstanding_le_2", (rd_idx - wr_idx - int'(m_xfer)) <= 2, 1);
            end
            if (bus.llr_wr_en) begin
                chk("wr_in_range", wr_idx < N, 1);
                if (wr_idx < N) begin
                    chk("wr_addr", bus.llr_wr_addr, wr_idx[AW-1:0]);
                    chk("wr_data", bus.llr_wr_data, lut_f(key_mem[wr_idx], m_q));
                    chk("wr_hard", bus.llr_wr_hard, key_mem[wr_idx]);
                    chk("lut_qber_sel", bus.lut_qber_sel, m_q);
                    got_data[wr_idx] = bus.llr_wr_data;
                    if (m_xfer) begin
                        wr_idx++;
                        m_last = (wr_idx == N);
                    end
                end
            end
            prev_hold = bus.llr_wr_en & ~bus.llr_wr_ready;
            prev_addr = bus.llr_wr_addr;
            prev_data = bus.llr_wr_data;
            prev_hard = bus.llr_wr_hard;
            // Expectations for the next cycle.
            m_done = m_last;
            m_err  = !m_busy && bus.start && (bus.qber_sel_in > 4'd10);
            if (!m_busy && bus.start && bus.qber_sel_in <= 4'd10) begin
                m_busy = 1'b1;
                m_q    = bus.qber_sel_in;
            end else if (m_last) begin
                m_busy = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err"}, bus.err_qber, 0);
        chk({tag, "_rd_en"}, bus.key_rd_en, 0);
        chk({tag, "_rd_addr"}, bus.key_rd_addr, 0);
        chk({tag, "_lut_xi"}, bus.lut_xi, 0);
        chk({tag, "_lut_q"}, bus.lut_qber_sel, 0);
        chk({tag, "_wr_en"}, bus.llr_wr_en, 0);
        chk({tag, "_wr_addr"}, bus.llr_wr_addr, 0);
        chk({tag, "_wr_data"}, bus.llr_wr_data, 0);
        chk({tag, "_wr_hard"}, bus.llr_wr_hard, 0);
    endtask

    // Called just after a rising edge; raises start for exactly one edge.
    task automatic pulse_start(input logic [3:0] q);
        bus.start = 1'b1;
        bus.qber_sel_in = q;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!bus.done && n < budget) begin @(posedge clk); #1; n++; end
        chk(name, bus.done, 1);
    endtask

    task automatic wait_write(input logic [AW-1:0] a, input int budget);
        int n = 0;
        while (!(bus.llr_wr_en && bus.llr_wr_addr == a) && n < budget) begin
            @(negedge clk); n++;
        end
        chk("wait_write_seen", bus.llr_wr_en && bus.llr_wr_addr == a, 1);
    endtask

    initial begin
        logic [LW-1:0] exp1 [N];
        logic [N-1:0]  key1;
        int seen;
        exp1 = '{15'h6D9F, 15'h1261, 15'h6D9F, 15'h6D9F, 15'h1261, 15'h1261, 15'h6D9F, 15'h1261};
        key1 = 8'b0100_1101;                 // bit i = key at address i: 1,0,1,1,0,0,1,0
        bus.start = 1'b0;
        bus.qber_sel_in = 4'd0;
        for (int i = 0; i < N; i++) key_mem[i] = key1[i];

        // Reset state.
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: qber 0, known key, ready high: 8 back-to-back writes.
        pulse_start(4'd0);
        chk("first_rd_latency", bus.key_rd_en, 1);
        seen = 0;
        while (!bus.llr_wr_en && seen < 10) begin @(posedge clk); #1; seen++; end
        for (int i = 0; i < N; i++) begin
            chk("t1_back_to_back", bus.llr_wr_en, 1);
            @(posedge clk); #1;
        end
        chk("t1_done_after_last", bus.done, 1);
        wait_done("t1_done", 5);
        for (int i = 0; i < N; i++) chk("t1_literal_data", got_data[i], exp1[i]);
        repeat (2) @(posedge clk); #1;

        // 2: out-of-range QBER.
        pulse_start(4'd11);
        chk("t2_err_pulse", bus.err_qber, 1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("t2_err_once", bus.err_qber, 0);
            chk("t2_no_busy", bus.busy, 0);
            chk("t2_no_read", bus.key_rd_en, 0);
            chk("t2_no_done", bus.done, 0);
        end

        // 3: ready low for three cycles starting at the third write.
        for (int i = 0; i < N; i++) key_mem[i] = 1'($urandom);
        pulse_start(4'd5);
        wait_write(3'd1, 20);
        rdy_mode = 2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_stall_addr", bus.llr_wr_addr, 2);
        end
        rdy_mode = 0;
        @(posedge clk); #1;
        wait_done("t3_done", 30);
        @(posedge clk); #1;

        // 4: qber 10, all-zero key; start and qber changes mid-run are ignored.
        for (int i = 0; i < N; i++) key_mem[i] = 1'b0;
        pulse_start(4'd10);
        @(posedge clk); #1;
        pulse_start(4'd3);
        wait_done("t4_done", 30);
        for (int i = 0; i < N; i++) chk("t4_literal_data", got_data[i], 15'h085D);
        bus.qber_sel_in = 4'd0;
        @(posedge clk); #1;

        // 5: reset asserted while write 4 is presented.
        for (int i = 0; i < N; i++) key_mem[i] = 1'($urandom);
        pulse_start(4'd2);
        wait_write(3'd4, 20);
        #1 rst_n = 1'b0;
        #1 chk_quiet("midrun_reset");
        @(negedge clk);
        @(negedge clk);
        chk("reset_no_done", bus.done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        pulse_start(4'd7);
        wait_done("t5_restart_done", 30);
        @(posedge clk); #1;

        // 6: random ready, chained runs, each next start issued in the done cycle.
        rdy_mode = 1;
        for (int i = 0; i < N; i++) key_mem[i] = 1'($urandom);
        pulse_start(4'($urandom_range(0, 10)));
        for (int r = 0; r < 8; r++) begin
            wait_done("t6_done", 200);
            if (r < 7) begin
                for (int i = 0; i < N; i++) key_mem[i] = 1'($urandom);
                pulse_start(4'($urandom_range(0, 10)));
            end
        end
        rdy_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("final_idle_busy", bus.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
